// File: rtl/fir_ctrl.sv
// Control sequencer for the 8-tap FIR datapath: sample handshake, shift/multiply
// strobes, registered result with backpressure, and delay-line flushing.
module fir_ctrl #(
  parameter int TAPS = 8,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x_in,
  input  logic                 flush,
  output logic                 dp_en,
  output logic signed [DW-1:0] dp_x,
  output logic                 dp_y_mult,
  output logic                 dp_x_clr,
  output logic                 dp_y_clr,
  input  logic signed [DW-1:0] dp_y,
  output logic signed [DW-1:0] y_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 primed,
  output logic                 busy
);

  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int NW = $clog2(TAPS + 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(TAPS - 1);
  localparam logic [NW-1:0] CNT_FULL   = NW'(TAPS);

  typedef enum logic [2:0] {FLUSH, IDLE, MULT, CAPT, HOLD} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   flush_cnt;
  logic [NW-1:0]   smp_cnt;
  logic            flush_pend;
  logic            flush_req;
  logic            accept;

  function automatic logic [NW-1:0] sat_inc(input logic [NW-1:0] c);
    return (c == CNT_FULL) ? c : c + NW'(1);
  endfunction

  assign flush_req = flush || flush_pend;
  assign accept    = (state == IDLE) && !flush_req && in_valid;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FLUSH;
      flush_cnt  <= '0;
      smp_cnt    <= '0;
      flush_pend <= 1'b0;
      y_out      <= '0;
      out_valid  <= 1'b0;
      primed     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        FLUSH: flush_cnt <= (flush_cnt == FLUSH_LAST) ? '0 : flush_cnt + CW'(1);
        IDLE: begin
          if (flush_req) begin
            flush_pend <= 1'b0;
            smp_cnt    <= '0;
            flush_cnt  <= '0;
          end else if (accept) begin
            smp_cnt <= sat_inc(smp_cnt);
          end
        end
        MULT: if (flush) flush_pend <= 1'b1;
        CAPT: begin
          if (flush) flush_pend <= 1'b1;
          y_out     <= dp_y;
          out_valid <= 1'b1;
          primed    <= (smp_cnt == CNT_FULL);
        end
        HOLD: begin
          if (flush) flush_pend <= 1'b1;
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The accepted sample is forwarded to dp combinationally so it shifts in at the accept edge.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    dp_en     = 1'b0;
    dp_x      = '0;
    dp_y_mult = 1'b0;
    dp_x_clr  = 1'b0;
    dp_y_clr  = 1'b0;
    case (state)
      FLUSH: begin
        dp_en    = 1'b1;
        dp_x_clr = 1'b1;
        dp_y_clr = (flush_cnt == '0);
        if (flush_cnt == FLUSH_LAST) state_nxt = IDLE;
      end
      IDLE: begin
        in_ready = !flush_req;
        if (flush_req) begin
          state_nxt = FLUSH;
        end else if (in_valid) begin
          dp_en     = 1'b1;
          dp_x      = x_in;
          state_nxt = MULT;
        end
      end
      MULT: begin
        dp_y_mult = 1'b1;
        state_nxt = CAPT;
      end
      CAPT: state_nxt = HOLD;
      HOLD: if (out_ready) state_nxt = IDLE;
      default: state_nxt = FLUSH;
    endcase
  end

endmodule

// File: doc/fir_ctrl.md
Name: fir_ctrl

Overview:
- Control sequencer that drives the 8-tap FIR datapath `dp`.
- Accepts 8-bit samples over a valid/ready handshake and issues the datapath shift-enable and multiply strobes.
- Captures the combinational filter output into a registered output with valid/ready backpressure, and clears the datapath delay line after reset and on request.
- Sits between the upstream sample source and `dp`; the downstream sink reads `y_out`.

Parameters:
- TAPS, 8, number of delay-line stages to clear on flush; must match `dp`.
- DW, 8, sample and result width (signed, Q1.7).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- x_in  input  DW  signed input sample.
- flush  input  1  one-cycle request to zero the delay line.
- dp_en  output  1  to `dp.en`; shifts `dp_x` into the delay line.
- dp_x  output  DW  to `dp.x`.
- dp_y_mult  output  1  to `dp.y_mult`; loads the product registers.
- dp_x_clr  output  1  to `dp.x_clr`; high for every cycle of a flush.
- dp_y_clr  output  1  to `dp.y_clr`; high in the first flush cycle.
- dp_y  input  DW  from `dp.y`; combinational sum of the product registers.
- y_out  output  DW  registered filter result.
- out_valid  output  1  `y_out` valid.
- out_ready  input  1  downstream accepts `y_out`.
- primed  output  1  registered; set when the delay line holds ≥TAPS real samples since the last flush.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: FLUSH, IDLE, MULT, CAPT, HOLD.
- Reset (rst=1 at an edge):
  - state←FLUSH, flush counter←0, sample count←0, flush_pend←0.
  - y_out←0, out_valid←0, primed←0.
  - This clears `dp`, which has no reset of its own.
- FLUSH:
  - dp_en=1, dp_x=0, dp_x_clr=1, in_ready=0.
  - Counter increments each cycle; after TAPS cycles (counter==TAPS-1) go to IDLE.
  - dp_y_clr=1 only in the cycle where counter==0.
- IDLE:
  - in_ready = !flush && !flush_pend.
  - flush or flush_pend → FLUSH; this clears flush_pend and sample count. Flush wins over a simultaneous in_valid, and no sample is accepted that cycle.
  - Else in_valid&&in_ready → accept: dp_en=1 and dp_x=x_in combinationally in the same cycle, sample count saturating-increments (cap TAPS), go to MULT.
- MULT: dp_y_mult=1 for exactly one cycle (products update at this edge) → CAPT.
- CAPT:
  - dp_y is now stable; at the edge y_out←dp_y, out_valid←1, primed←(sample count==TAPS).
  - Go to HOLD.
- HOLD:
  - out_valid=1; y_out and primed held stable.
  - out_ready=1 → out_valid←0, go to IDLE.
- dp_en, dp_y_mult, dp_x_clr and dp_y_clr are 0 in all cases not listed; dp_x=0 whenever dp_en=0.
- flush seen in MULT/CAPT/HOLD sets flush_pend; it is serviced at the next IDLE, and the in-flight result completes normally first.
- Latency: accept edge → out_valid high 3 edges later (accept@k, MULT@k+1, CAPT@k+2, out_valid visible in cycle k+3).
- Maximum throughput: 1 sample per 4 cycles with out_ready tied high.
- Arithmetic is done entirely in `dp` (Q1.7 product truncation, 8-bit wrap on the sum); this block never modifies dp_y.
- rst mid-operation: an in-flight sample is abandoned, out_valid drops at that edge, and the full flush sequence runs.

Test Plan:
- Reset, then idle → in_ready=0 and dp_en=1, dp_x=0 for exactly 8 cycles; dp_y_clr high only in the first; then in_ready=1, busy=0.
- With `dp` attached, all b=0x40, send x=0x20 ×7 with out_ready=1 → y_out=0x10,0x20,…,0x70; primed=0 on all seven; out_valid arrives 3 cycles after each accept.
- Eighth x=0x20 → y_out=0x80 (8-bit wrap from `dp`), primed=1; a ninth sample keeps primed=1.
- Hold out_ready=0 for 10 cycles after a result → y_out and out_valid stable, in_ready=0 throughout; raise out_ready → out_valid drops next edge, in_ready=1 the cycle after.
- Assert flush together with in_valid in IDLE → sample not accepted (in_ready=0) and an 8-cycle flush runs. Then the impulse x=0x40 followed by 0x00 with b0=0x7F, others 0 → y_out=0x3F, then 0x00.
- Pulse flush during MULT → current result delivered unchanged, then flush runs at IDLE; pulse rst during CAPT → out_valid=0 at the next edge and the flush restarts.
